// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the DataPath. It runs the fetch sequence
// (T0..T2), latches the opcode from IR[31:27] at the T2->T3 edge, and then
// steps the execute T-states for that opcode group. It takes one state per
// Clock cycle. Every strobe comes straight from a flop, so the DataPath sees
// glitch-free controls. The flops load the decode of the *next* state, which
// means a strobe is high for exactly the cycle its T-state is current.
//
// Ports
//   Clock, clear          rising-edge clock, async active-low reset
//   IR[31:0]              instruction register (only [31:27] is used)
//   CON_FF                branch condition from DataPath, used by br T6
//   stop                  level; parks in T0 (no strobes) before a new fetch
//   *out / *in / misc     one-hot DataPath control strobes
//   operation[OPW-1:0]    ALU op for the ALU step, ALU_ADD for address adds
//   run                   high while executing, low in RESET and HALT
//   illegal_op            one-cycle pulse in T3 for an undefined opcode
//   dbg_state_o           current sequencer state, for observation only
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int unsigned    OPW      = 5,
  parameter logic [OPW-1:0] ALU_ADD  = 5'b00011,
  parameter int unsigned    MEM_WAIT = 0
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           HIout,
  output logic           LOout,
  output logic           MDRout,
  output logic           In_Portout,
  output logic           Cout,
  output logic           BAout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin_low,
  output logic           Zin_high,
  output logic           HIin,
  output logic           LOin,
  output logic           r_in,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rout,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           ConIn,
  output logic           outPortenable,
  output logic [OPW-1:0] operation,
  output logic           run,
  output logic           illegal_op,
  output logic [3:0]     dbg_state_o
);

  // Opcode map (IR[31:27])
  localparam logic [OPW-1:0] OP_LD      = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI     = 5'b00001;
  localparam logic [OPW-1:0] OP_ST      = 5'b00010;
  localparam logic [OPW-1:0] OP_R_FIRST = 5'b00011;
  localparam logic [OPW-1:0] OP_R_LAST  = 5'b01011;
  localparam logic [OPW-1:0] OP_I_FIRST = 5'b01100;
  localparam logic [OPW-1:0] OP_I_LAST  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL     = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV     = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG     = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT     = 5'b10010;
  localparam logic [OPW-1:0] OP_BR      = 5'b10011;
  localparam logic [OPW-1:0] OP_JR      = 5'b10100;
  localparam logic [OPW-1:0] OP_IN      = 5'b10110;
  localparam logic [OPW-1:0] OP_OUT     = 5'b10111;
  localparam logic [OPW-1:0] OP_MFHI    = 5'b11000;
  localparam logic [OPW-1:0] OP_MFLO    = 5'b11001;
  localparam logic [OPW-1:0] OP_NOP     = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT    = 5'b11011;

  localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

  // T0..T7 must stay consecutive: the execute steps advance by +1.
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_PARK  = 4'd1,   // T0 held with no strobes while stop is high
    S_HALT  = 4'd2,
    S_T0    = 4'd3,
    S_T1    = 4'd4,
    S_T2    = 4'd5,
    S_T3    = 4'd6,
    S_T4    = 4'd7,
    S_T5    = 4'd8,
    S_T6    = 4'd9,
    S_T7    = 4'd10
  } state_t;

  typedef struct packed {
    logic           pc_out;
    logic           zlow_out;
    logic           zhigh_out;
    logic           hi_out;
    logic           lo_out;
    logic           mdr_out;
    logic           in_port_out;
    logic           c_out;
    logic           ba_out;
    logic           mar_in;
    logic           pc_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           z_in;       // drives both Zin_low and Zin_high
    logic           hi_in;
    logic           lo_in;
    logic           r_in;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           rout;
    logic           inc_pc;
    logic           read;
    logic           write;
    logic           con_in;
    logic           out_port_en;
    logic           illegal_op;
    logic [OPW-1:0] operation;
  } strobes_t;

  state_t         state_q, state_d;
  logic [2:0]     wait_q, wait_d;
  logic [OPW-1:0] op_q, op_d;
  strobes_t       str_q, str_d;
  logic           run_q;
  logic           done;
  logic           mem_state;

  // Only the opcode field of IR is meaningful to the sequencer.
  logic unused_ir;
  assign unused_ir = ^IR[31-OPW:0];

  // Final execute state of each opcode group; the step after it is T0.
  function automatic state_t last_step(input logic [OPW-1:0] op);
    case (op) inside
      OP_LD, OP_ST:                              last_step = S_T7;
      OP_LDI, [OP_R_FIRST:OP_R_LAST],
      [OP_I_FIRST:OP_I_LAST]:                    last_step = S_T5;
      OP_MUL, OP_DIV, OP_BR:                     last_step = S_T6;
      OP_NEG, OP_NOT:                            last_step = S_T4;
      default:                                   last_step = S_T3;
    endcase
  endfunction

  // T1 and the ld data read hold Read/MDRin for 1+MEM_WAIT cycles.
  assign mem_state = (state_q == S_T1) || ((state_q == S_T6) && (op_q == OP_LD));

  // Next state
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    op_d    = op_q;
    done    = 1'b0;
    unique case (state_q)
      S_RESET, S_PARK: done = 1'b1;
      S_HALT:          state_d = S_HALT;
      S_T2: begin
        state_d = S_T3;
        op_d    = IR[31 -: OPW];
      end
      default: begin
        if (mem_state && (wait_q != WAIT_MAX)) begin
          wait_d = wait_q + 3'd1;
        end else if ((state_q == S_T3) && (op_q == OP_HALT)) begin
          state_d = S_HALT;
        end else if (state_q == last_step(op_q)) begin
          done = 1'b1;
        end else begin
          state_d = state_t'(state_q + 4'd1);
        end
      end
    endcase
    // stop is looked at only on the way into T0, so it never cuts an
    // instruction short.
    if (done) begin
      state_d = stop ? S_PARK : S_T0;
    end
  end

  // Strobe decode of the state being entered; op_d already carries the new
  // opcode when entering T3.
  always_comb begin
    str_d = '0;
    unique case (state_d)
      S_T0: begin
        str_d.pc_out = 1'b1; str_d.mar_in = 1'b1; str_d.inc_pc = 1'b1; str_d.z_in = 1'b1;
      end
      S_T1: begin
        str_d.zlow_out = 1'b1; str_d.pc_in = 1'b1; str_d.read = 1'b1; str_d.mdr_in = 1'b1;
      end
      S_T2: begin
        str_d.mdr_out = 1'b1; str_d.ir_in = 1'b1;
      end
      S_T3: begin
        case (op_d) inside
          [OP_R_FIRST:OP_R_LAST], [OP_I_FIRST:OP_I_LAST]: begin
            str_d.grb = 1'b1; str_d.rout = 1'b1; str_d.y_in = 1'b1;
          end
          OP_LD, OP_LDI, OP_ST: begin
            str_d.grb = 1'b1; str_d.ba_out = 1'b1; str_d.y_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            str_d.gra = 1'b1; str_d.rout = 1'b1; str_d.y_in = 1'b1;
          end
          OP_NEG, OP_NOT: begin
            str_d.grb = 1'b1; str_d.rout = 1'b1; str_d.z_in = 1'b1; str_d.operation = op_d;
          end
          OP_BR: begin
            str_d.gra = 1'b1; str_d.rout = 1'b1; str_d.con_in = 1'b1;
          end
          OP_JR: begin
            str_d.gra = 1'b1; str_d.rout = 1'b1; str_d.pc_in = 1'b1;
          end
          OP_IN: begin
            str_d.gra = 1'b1; str_d.r_in = 1'b1; str_d.in_port_out = 1'b1;
          end
          OP_OUT: begin
            str_d.gra = 1'b1; str_d.rout = 1'b1; str_d.out_port_en = 1'b1;
          end
          OP_MFHI: begin
            str_d.gra = 1'b1; str_d.r_in = 1'b1; str_d.hi_out = 1'b1;
          end
          OP_MFLO: begin
            str_d.gra = 1'b1; str_d.r_in = 1'b1; str_d.lo_out = 1'b1;
          end
          OP_NOP, OP_HALT: ;
          default: str_d.illegal_op = 1'b1;
        endcase
      end
      S_T4: begin
        case (op_d) inside
          [OP_R_FIRST:OP_R_LAST]: begin
            str_d.grc = 1'b1; str_d.rout = 1'b1; str_d.z_in = 1'b1; str_d.operation = op_d;
          end
          [OP_I_FIRST:OP_I_LAST]: begin
            str_d.c_out = 1'b1; str_d.z_in = 1'b1; str_d.operation = op_d;
          end
          OP_LD, OP_LDI, OP_ST: begin
            str_d.c_out = 1'b1; str_d.z_in = 1'b1; str_d.operation = ALU_ADD;
          end
          OP_MUL, OP_DIV: begin
            str_d.grb = 1'b1; str_d.rout = 1'b1; str_d.z_in = 1'b1; str_d.operation = op_d;
          end
          OP_NEG, OP_NOT: begin
            str_d.zlow_out = 1'b1; str_d.gra = 1'b1; str_d.r_in = 1'b1;
          end
          OP_BR: begin
            str_d.pc_out = 1'b1; str_d.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_d) inside
          OP_LDI, [OP_R_FIRST:OP_R_LAST], [OP_I_FIRST:OP_I_LAST]: begin
            str_d.zlow_out = 1'b1; str_d.gra = 1'b1; str_d.r_in = 1'b1;
          end
          OP_LD, OP_ST: begin
            str_d.zlow_out = 1'b1; str_d.mar_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            str_d.zlow_out = 1'b1; str_d.lo_in = 1'b1;
          end
          OP_BR: begin
            str_d.c_out = 1'b1; str_d.z_in = 1'b1; str_d.operation = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_d) inside
          OP_LD: begin
            str_d.read = 1'b1; str_d.mdr_in = 1'b1;
          end
          OP_ST: begin
            str_d.gra = 1'b1; str_d.rout = 1'b1; str_d.mdr_in = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            str_d.zhigh_out = 1'b1; str_d.hi_in = 1'b1;
          end
          // Untaken branch still spends T6, just without loading PC.
          OP_BR: begin
            str_d.zlow_out = CON_FF; str_d.pc_in = CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_d) inside
          OP_LD: begin
            str_d.mdr_out = 1'b1; str_d.gra = 1'b1; str_d.r_in = 1'b1;
          end
          OP_ST: str_d.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      op_q    <= '0;
      str_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      str_q   <= str_d;
      run_q   <= (state_d != S_RESET) && (state_d != S_HALT);
    end
  end

  assign PCout         = str_q.pc_out;
  assign Zlowout       = str_q.zlow_out;
  assign Zhighout      = str_q.zhigh_out;
  assign HIout         = str_q.hi_out;
  assign LOout         = str_q.lo_out;
  assign MDRout        = str_q.mdr_out;
  assign In_Portout    = str_q.in_port_out;
  assign Cout          = str_q.c_out;
  assign BAout         = str_q.ba_out;
  assign MARin         = str_q.mar_in;
  assign PCin          = str_q.pc_in;
  assign MDRin         = str_q.mdr_in;
  assign IRin          = str_q.ir_in;
  assign Yin           = str_q.y_in;
  assign Zin_low       = str_q.z_in;
  assign Zin_high      = str_q.z_in;
  assign HIin          = str_q.hi_in;
  assign LOin          = str_q.lo_in;
  assign r_in          = str_q.r_in;
  assign Gra           = str_q.gra;
  assign Grb           = str_q.grb;
  assign Grc           = str_q.grc;
  assign Rout          = str_q.rout;
  assign IncPC         = str_q.inc_pc;
  assign Read          = str_q.read;
  assign Write         = str_q.write;
  assign ConIn         = str_q.con_in;
  assign outPortenable = str_q.out_port_en;
  assign illegal_op    = str_q.illegal_op;
  assign operation     = str_q.operation;
  assign run           = run_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. The reference model expands each instruction
// into the list of strobe sets it must produce, one entry per cycle, straight
// from the opcode table; the scoreboard pops one entry per clock.
module tb_control_sequencer;

  localparam int MW = 2;
  localparam int W  = 34;

  // Bench-side strobe packing: bits 0..8 bus drivers, 9..28 other strobes,
  // 33..29 operation.
  localparam logic [W-1:0] PCO   = 34'd1 << 0;
  localparam logic [W-1:0] ZLO   = 34'd1 << 1;
  localparam logic [W-1:0] ZHI   = 34'd1 << 2;
  localparam logic [W-1:0] HIO   = 34'd1 << 3;
  localparam logic [W-1:0] LOO   = 34'd1 << 4;
  localparam logic [W-1:0] MDRO  = 34'd1 << 5;
  localparam logic [W-1:0] INPO  = 34'd1 << 6;
  localparam logic [W-1:0] COUT  = 34'd1 << 7;
  localparam logic [W-1:0] BAO   = 34'd1 << 8;
  localparam logic [W-1:0] MARI  = 34'd1 << 9;
  localparam logic [W-1:0] PCI   = 34'd1 << 10;
  localparam logic [W-1:0] MDRI  = 34'd1 << 11;
  localparam logic [W-1:0] IRI   = 34'd1 << 12;
  localparam logic [W-1:0] YIN   = 34'd1 << 13;
  localparam logic [W-1:0] ZIN   = (34'd1 << 14) | (34'd1 << 15);
  localparam logic [W-1:0] HII   = 34'd1 << 16;
  localparam logic [W-1:0] LOI   = 34'd1 << 17;
  localparam logic [W-1:0] RIN   = 34'd1 << 18;
  localparam logic [W-1:0] GRA   = 34'd1 << 19;
  localparam logic [W-1:0] GRB   = 34'd1 << 20;
  localparam logic [W-1:0] GRC   = 34'd1 << 21;
  localparam logic [W-1:0] ROUT  = 34'd1 << 22;
  localparam logic [W-1:0] INCPC = 34'd1 << 23;
  localparam logic [W-1:0] RD    = 34'd1 << 24;
  localparam logic [W-1:0] WR    = 34'd1 << 25;
  localparam logic [W-1:0] CONIN = 34'd1 << 26;
  localparam logic [W-1:0] OUTPE = 34'd1 << 27;
  localparam logic [W-1:0] ILL   = 34'd1 << 28;
  localparam logic [4:0]   ADD_OP = 5'b00011;

  // clock/reset block
  logic Clock = 1'b0;
  logic clear = 1'b0;
  always #5 Clock = ~Clock;

  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0;
  logic        stop = 1'b0;
  logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, BAout;
  logic MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, r_in;
  logic Gra, Grb, Grc, Rout, IncPC, Read, Write, ConIn, outPortenable;
  logic [4:0] operation;
  logic run, illegal_op;
  logic [3:0] dbg_state;

  control_sequencer #(.OPW(5), .ALU_ADD(ADD_OP), .MEM_WAIT(MW)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout), .BAout(BAout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin_low(Zin_low), .Zin_high(Zin_high), .HIin(HIin), .LOin(LOin), .r_in(r_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .IncPC(IncPC), .Read(Read),
    .Write(Write), .ConIn(ConIn), .outPortenable(outPortenable),
    .operation(operation), .run(run), .illegal_op(illegal_op), .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] observe();
    return {operation, illegal_op, outPortenable, ConIn, Write, Read, IncPC, Rout, Grc, Grb,
            Gra, r_in, LOin, HIin, Zin_high, Zin_low, Yin, IRin, MDRin, PCin, MARin,
            BAout, Cout, In_Portout, MDRout, LOout, HIout, Zhighout, Zlowout, PCout};
  endfunction

  function automatic logic [W-1:0] op_f(input logic [4:0] o);
    logic [W-1:0] v;
    v = '0;
    v[33:29] = o;
    return v;
  endfunction

  // Reference model: per-cycle strobe list for one instruction.
  task automatic build_exp(input logic [4:0] opc, input logic cf);
    exp_q.delete();
    exp_q.push_back(PCO | MARI | INCPC | ZIN);
    for (int k = 0; k <= MW; k++) exp_q.push_back(ZLO | PCI | RD | MDRI);
    exp_q.push_back(MDRO | IRI);
    case (opc) inside
      [5'd3:5'd11]: begin
        exp_q.push_back(GRB | ROUT | YIN);
        exp_q.push_back(GRC | ROUT | ZIN | op_f(opc));
        exp_q.push_back(ZLO | GRA | RIN);
      end
      [5'd12:5'd14]: begin
        exp_q.push_back(GRB | ROUT | YIN);
        exp_q.push_back(COUT | ZIN | op_f(opc));
        exp_q.push_back(ZLO | GRA | RIN);
      end
      [5'd0:5'd2]: begin
        exp_q.push_back(GRB | BAO | YIN);
        exp_q.push_back(COUT | ZIN | op_f(ADD_OP));
        if (opc == 5'd1) begin
          exp_q.push_back(ZLO | GRA | RIN);
        end else begin
          exp_q.push_back(ZLO | MARI);
          if (opc == 5'd0) begin
            for (int k = 0; k <= MW; k++) exp_q.push_back(RD | MDRI);
            exp_q.push_back(MDRO | GRA | RIN);
          end else begin
            exp_q.push_back(GRA | ROUT | MDRI);
            exp_q.push_back(WR);
          end
        end
      end
      5'd15, 5'd16: begin
        exp_q.push_back(GRA | ROUT | YIN);
        exp_q.push_back(GRB | ROUT | ZIN | op_f(opc));
        exp_q.push_back(ZLO | LOI);
        exp_q.push_back(ZHI | HII);
      end
      5'd17, 5'd18: begin
        exp_q.push_back(GRB | ROUT | ZIN | op_f(opc));
        exp_q.push_back(ZLO | GRA | RIN);
      end
      5'd19: begin
        exp_q.push_back(GRA | ROUT | CONIN);
        exp_q.push_back(PCO | YIN);
        exp_q.push_back(COUT | ZIN | op_f(ADD_OP));
        exp_q.push_back(cf ? (ZLO | PCI) : '0);
      end
      5'd20: exp_q.push_back(GRA | ROUT | PCI);
      5'd22: exp_q.push_back(GRA | RIN | INPO);
      5'd23: exp_q.push_back(GRA | ROUT | OUTPE);
      5'd24: exp_q.push_back(GRA | RIN | HIO);
      5'd25: exp_q.push_back(GRA | RIN | LOO);
      5'd26, 5'd27: exp_q.push_back('0);
      default: exp_q.push_back(ILL);
    endcase
  endtask

  // Driver: must be entered with the DUT about to show T0 at the next negedge.
  // abort_at >= 0 pulls clear low right after that step is checked.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic cf,
                           input int abort_at);
    logic [W-1:0] e, obs;
    int n;
    build_exp(ir[31:27], cf);
    IR = ir;
    CON_FF = cf;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge Clock);
      obs = observe();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s step %0d strobes: got %h want %h", tag, n, obs, e);
      end
      total++;
      if (run !== 1'b1) begin
        bad++;
        $display("FAIL %s step %0d run: got %b want 1", tag, n, run);
      end
      total++;
      if ($countones(obs[8:0]) > 1) begin
        bad++;
        $display("FAIL %s step %0d bus drivers: got %b want at most one", tag, n, obs[8:0]);
      end
      // Opcode is already latched; later IR values must not matter.
      if (n == MW + 3) IR = $urandom();
      if (n == abort_at) begin
        clear = 1'b0;
        #1;
        obs = observe();
        total++;
        if (obs !== '0 || run !== 1'b0) begin
          bad++;
          $display("FAIL %s async clear: got %h run=%b want 0 run=0", tag, obs, run);
        end
        exp_q.delete();
        @(negedge Clock);
        clear = 1'b1;
      end
      n++;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] obs;
    clear = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      obs = observe();
      total++;
      if (obs !== '0 || run !== 1'b0) begin
        bad++;
        $display("FAIL reset: got %h run=%b want 0 run=0", obs, run);
      end
    end
    clear = 1'b1;
  endtask

  task automatic test_jr();
    run_instr("jr", 32'hA0800000, 1'b0, -1);
    run_instr("after_jr", 32'hD0000000, 1'b0, -1);
  endtask

  task automatic test_add();
    run_instr("add", 32'h18918000, 1'b0, -1);
  endtask

  task automatic test_ld();
    run_instr("ld", 32'h00800005, 1'b0, -1);
    run_instr("st", 32'h10800005, 1'b1, -1);
  endtask

  task automatic test_br();
    run_instr("br_nt", 32'h98000010, 1'b0, -1);
    run_instr("br_t", 32'h98000010, 1'b1, -1);
  endtask

  task automatic test_stop();
    logic [W-1:0] obs;
    stop = 1'b1;
    repeat (5) begin
      @(negedge Clock);
      obs = observe();
      total++;
      if (obs !== '0 || run !== 1'b1) begin
        bad++;
        $display("FAIL stop park: got %h run=%b want 0 run=1", obs, run);
      end
    end
    stop = 1'b0;
    run_instr("after_stop", 32'h78000000, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [4:0] opc;
    for (int i = 0; i < 40; i++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      run_instr("random", {opc, 27'($urandom())}, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_clear_mid();
    run_instr("clr_ld", 32'h00800005, 1'b0, MW + 5);
    run_instr("after_clr", 32'h88000000, 1'b0, -1);
  endtask

  task automatic test_halt();
    logic [W-1:0] obs;
    run_instr("halt", 32'hD8000000, 1'b0, -1);
    repeat (20) begin
      @(negedge Clock);
      obs = observe();
      total++;
      if (obs !== '0 || run !== 1'b0) begin
        bad++;
        $display("FAIL halt hold: got %h run=%b want 0 run=0", obs, run);
      end
    end
    clear = 1'b0;
    #1;
    obs = observe();
    total++;
    if (obs !== '0 || run !== 1'b0) begin
      bad++;
      $display("FAIL halt clear: got %h run=%b want 0 run=0", obs, run);
    end
    @(negedge Clock);
    clear = 1'b1;
    run_instr("after_halt", 32'hA0800000, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_jr();
    test_add();
    test_ld();
    test_br();
    test_stop();
    test_random();
    test_clear_mid();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
